// File: rtl/dem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dem_pkg : shared widths, element-count helper and typedefs for DEM   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package dem_pkg;

  localparam int DEM_CODE_WIDTH = 3;

  function automatic int dem_num_elements(input int code_width);
    return (1 << code_width) - 1;
  endfunction

  localparam int DEM_PTR_WIDTH = $clog2(dem_num_elements(DEM_CODE_WIDTH));

  typedef logic [DEM_CODE_WIDTH-1:0] dem_code_t;
  typedef logic [DEM_PTR_WIDTH-1:0]  dem_ptr_t;

endpackage
`default_nettype wire

// File: rtl/rotating_thermometer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rotating_thermometer : k-ones thermometer rotated left by the pointer|
// | plus the wrapped next pointer (combinational). Rev 1.0               |
// +----------------------------------------------------------------------+
module rotating_thermometer
  import dem_pkg::*;
#(
  parameter int CODE_WIDTH   = DEM_CODE_WIDTH,
  parameter int NUM_ELEMENTS = dem_num_elements(CODE_WIDTH),
  parameter int PTR_WIDTH    = $clog2(NUM_ELEMENTS)
) (
  input  logic [CODE_WIDTH-1:0]   i_code,
  input  logic [PTR_WIDTH-1:0]    i_ptr,
  output logic [NUM_ELEMENTS-1:0] o_mask,
  output logic [PTR_WIDTH-1:0]    o_next_ptr
);

  localparam int SW = PTR_WIDTH + 1;

  logic [SW-1:0]           w_k;
  logic [SW-1:0]           w_sum;
  logic [NUM_ELEMENTS-1:0] w_therm;

  // Codes above the element count only occur with an overridden NUM_ELEMENTS.
  always_comb begin
    if (int'(i_code) > NUM_ELEMENTS) w_k = SW'(NUM_ELEMENTS);
    else                             w_k = SW'(i_code);
  end

  always_comb begin
    w_therm = '0;
    for (int i = 0; i < NUM_ELEMENTS; i++) begin
      w_therm[i] = (i < int'(w_k));
    end
  end

  assign o_mask = (w_therm << i_ptr) | (w_therm >> (NUM_ELEMENTS - int'(i_ptr)));

  // ptr + k never exceeds 2*NUM_ELEMENTS-1, so a single conditional subtract wraps it.
  assign w_sum = {1'b0, i_ptr} + w_k;

  always_comb begin
    if (int'(w_sum) >= NUM_ELEMENTS) o_next_ptr = PTR_WIDTH'(w_sum - SW'(NUM_ELEMENTS));
    else                             o_next_ptr = PTR_WIDTH'(w_sum);
  end

endmodule
`default_nettype wire

// File: rtl/dwa_element_selector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dwa_element_selector : DWA unit-element selector for the multi-bit   |
// | DAC. DEM_DWA_ROTATE_EN enables rotation, else plain thermometer.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dwa_element_selector
  import dem_pkg::*;
#(
  parameter int CODE_WIDTH   = DEM_CODE_WIDTH,
  parameter int NUM_ELEMENTS = dem_num_elements(CODE_WIDTH),
  parameter int PTR_WIDTH    = $clog2(NUM_ELEMENTS)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [CODE_WIDTH-1:0]   code_i,
  input  logic                    code_valid_i,
  output logic [NUM_ELEMENTS-1:0] elem_sel_o,
  output logic                    elem_valid_o,
  output logic [PTR_WIDTH-1:0]    ptr_o
);

  logic [PTR_WIDTH-1:0]    r_ptr;
  logic [NUM_ELEMENTS-1:0] r_sel;
  logic                    r_valid;

  logic [PTR_WIDTH-1:0]    w_ptr_in;
  logic [PTR_WIDTH-1:0]    w_ptr_nxt;
  logic [PTR_WIDTH-1:0]    w_rot_next;
  logic [NUM_ELEMENTS-1:0] w_mask;

  rotating_thermometer #(
    .CODE_WIDTH   (CODE_WIDTH),
    .NUM_ELEMENTS (NUM_ELEMENTS),
    .PTR_WIDTH    (PTR_WIDTH)
  ) u_rot (
    .i_code     (code_i),
    .i_ptr      (w_ptr_in),
    .o_mask     (w_mask),
    .o_next_ptr (w_rot_next)
  );

`ifdef DEM_DWA_ROTATE_EN
  assign w_ptr_in  = r_ptr;
  assign w_ptr_nxt = w_rot_next;
`else
  // Pointer pinned at zero turns the rotator into a plain thermometer encoder.
  logic [PTR_WIDTH-1:0] w_unused_next;
  assign w_unused_next = w_rot_next;
  assign w_ptr_in      = '0;
  assign w_ptr_nxt     = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr   <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
    end else if (code_valid_i) begin
      r_ptr   <= w_ptr_nxt;
      r_sel   <= w_mask;
      r_valid <= 1'b1;
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign elem_sel_o   = r_sel;
  assign elem_valid_o = r_valid;
  assign ptr_o        = r_ptr;

endmodule
`default_nettype wire
